// File: rtl/lcg_stream.sv
// Iterating LCG source: X(n+1) = (a*X(n) + c) mod m, streamed out
// over valid/ready. Multiply once, then restoring reduction MSB first.
module lcg_stream #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         seed_valid,
  output logic         seed_ready,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] MODULUS,
  input  logic [W-1:0] MULTIPLIER,
  input  logic [W-1:0] INCREMENT,
  input  logic         stop,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_value,
  output logic         busy,
  output logic         err_mod_zero
);

  localparam int KW = $clog2(2 * W);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RED,
    HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   c_q, c_d;
  logic [W-1:0]   m_q, m_d;
  logic [2*W-1:0] t_q, t_d;
  logic [W:0]     r_q, r_d;
  logic [KW-1:0]  k_q, k_d;
  logic           fin_q, fin_d;
  logic [W-1:0]   out_q, out_d;
  logic           err_q, err_d;

  logic           seed_hs;
  logic [W:0]     r_sh;
  logic [W:0]     r_sub;
  logic           r_ge;

  assign seed_ready   = (state_q == IDLE) ||
                        (state_q == HOLD);
  assign busy         = (state_q == MUL) ||
                        (state_q == RED);
  assign out_valid    = (state_q == HOLD);
  assign out_value    = out_q;
  assign err_mod_zero = err_q;

  assign seed_hs = seed_valid & seed_ready;
  assign r_sh    = {r_q[W-1:0], t_q[2*W-1]};
  assign r_ge    = (r_sh >= {1'b0, m_q});
  assign r_sub   = r_sh - {1'b0, m_q};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    c_d     = c_q;
    m_d     = m_q;
    t_d     = t_q;
    r_d     = r_q;
    k_d     = k_q;
    fin_d   = fin_q;
    out_d   = out_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: ;
      MUL: begin
        t_d     = {{W{1'b0}}, a_q} * {{W{1'b0}}, x_q}
                + {{W{1'b0}}, c_q};
        r_d     = '0;
        k_d     = KW'(2 * W - 1);
        fin_d   = 1'b0;
        state_d = RED;
      end
      RED: begin
        if (fin_q) begin
          out_d   = r_q[W-1:0];
          state_d = HOLD;
        end else begin
          r_d = r_ge ? r_sub : r_sh;
          t_d = t_q << 1;
          if (k_q == '0) fin_d = 1'b1;
          else k_d = k_q - 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          x_d     = out_q;
          state_d = MUL;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new seed drops any pending output in HOLD
    if (seed_hs) begin
      if (MODULUS != '0) begin
        x_d     = seed;
        a_d     = MULTIPLIER;
        c_d     = INCREMENT;
        m_d     = MODULUS;
        err_d   = 1'b0;
        state_d = MUL;
      end else begin
        x_d     = x_q;
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end

    if (stop) begin
      x_d     = x_q;
      state_d = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      x_q     <= '0;
      a_q     <= '0;
      c_q     <= '0;
      m_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      fin_q   <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      c_q     <= c_d;
      m_q     <= m_d;
      t_q     <= t_d;
      r_q     <= r_d;
      k_q     <= k_d;
      fin_q   <= fin_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lcg_stream.sv
// Bench for lcg_stream: directed corner cases plus a
// randomized stream against a 64-bit arithmetic model.
module tb_lcg_stream;

  logic        clk;
  logic        rst_n;
  logic        seed_valid;
  logic        seed_ready;
  logic [31:0] seed;
  logic [31:0] modulus;
  logic [31:0] mult;
  logic [31:0] incr;
  logic        stop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic        busy;
  logic        err_mod_zero;

  int pass_cnt;
  int fail_cnt;
  int total;

  lcg_stream #(.W(32)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .seed_valid   (seed_valid),
    .seed_ready   (seed_ready),
    .seed         (seed),
    .MODULUS      (modulus),
    .MULTIPLIER   (mult),
    .INCREMENT    (incr),
    .stop         (stop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_value    (out_value),
    .busy         (busy),
    .err_mod_zero (err_mod_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] lcg_ref(
    input logic [31:0] x,
    input logic [31:0] a,
    input logic [31:0] c,
    input logic [31:0] m
  );
    logic [63:0] p;
    p = 64'(a) * 64'(x) + 64'(c);
    return p % 64'(m);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_seed(
    input logic [31:0] s,
    input logic [31:0] m,
    input logic [31:0] a,
    input logic [31:0] c
  );
    seed       = s;
    modulus    = m;
    mult       = a;
    incr       = c;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          n;
    logic [63:0] exp_v;
    logic [31:0] s, m, a, c;
    bit          rise;

    pass_cnt   = 0;
    fail_cnt   = 0;
    total      = 0;
    rst_n      = 1'b0;
    seed_valid = 1'b0;
    seed       = '0;
    modulus    = '0;
    mult       = '0;
    incr       = '0;
    stop       = 1'b0;
    out_ready  = 1'b0;

    #12;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_value", 64'(out_value), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_err", 64'(err_mod_zero), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_seed_ready", 64'(seed_ready), 1);

    // Known sequence and first-output latency
    send_seed(32'd96, 32'd993441, 32'd4001, 32'd60211);
    chk("mul_busy", 64'(busy), 1);
    chk("mul_seed_ready", 64'(seed_ready), 0);
    wait_valid(lat);
    chk("seq0_latency", 64'(lat), 66);
    chk("seq0_value", 64'(out_value), 444307);

    // Backpressure with parameter inputs wiggling
    rise = 1'b1;
    for (int i = 0; i < 20; i++) begin
      modulus = $urandom;
      mult    = $urandom;
      incr    = $urandom;
      tick();
      if (!out_valid || out_value != 32'd444307)
        rise = 1'b0;
    end
    chk("bp_stable", 64'(rise), 1);
    consume();
    chk("bp_consumed", 64'(out_valid), 0);
    wait_valid(lat);
    chk("seq1_latency", 64'(lat), 66);
    chk("seq1_value", 64'(out_value), 466569);

    // All-ones extremes
    send_seed('1, '1, '1, '1);
    wait_valid(lat);
    chk("ones_latency", 64'(lat), 66);
    chk("ones_value", 64'(out_value), 0);

    // m == 1
    send_seed($urandom, 32'd1, $urandom, $urandom);
    wait_valid(lat);
    chk("m1_value", 64'(out_value), 0);

    // stop mid-RED
    send_seed(32'd5, 32'd1000, 32'd7, 32'd3);
    repeat (30) tick();
    chk("red_busy", 64'(busy), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid", 64'(out_valid), 0);
    chk("stop_busy", 64'(busy), 0);
    chk("stop_ready", 64'(seed_ready), 1);

    // m == 0 from IDLE
    send_seed(32'd9, 32'd0, 32'd3, 32'd4);
    chk("m0_err", 64'(err_mod_zero), 1);
    chk("m0_busy", 64'(busy), 0);
    rise = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (out_valid || busy) rise = 1'b1;
    end
    chk("m0_quiet", 64'(rise), 0);

    // Seed in HOLD beats out_ready
    send_seed(32'd11, 32'd65521, 32'd75, 32'd74);
    chk("err_cleared", 64'(err_mod_zero), 0);
    wait_valid(lat);
    chk("p0_value", 64'(out_value),
        lcg_ref(11, 75, 74, 65521));
    out_ready = 1'b1;
    send_seed(32'd12345, 32'd100003, 32'd31, 32'd17);
    out_ready = 1'b0;
    wait_valid(lat);
    chk("prio_latency", 64'(lat), 66);
    chk("prio_value", 64'(out_value),
        lcg_ref(12345, 31, 17, 100003));

    // seed_valid during RED is ignored
    exp_v = lcg_ref(32'(out_value), 31, 17, 100003);
    consume();
    repeat (10) tick();
    seed_valid = 1'b1;
    seed       = 32'd777;
    modulus    = 32'd13;
    chk("red_seed_ready", 64'(seed_ready), 0);
    tick();
    seed_valid = 1'b0;
    wait_valid(lat);
    chk("ign_latency", 64'(lat + 11), 66);
    chk("ign_value", 64'(out_value), exp_v);

    // Async reset between edges, mid-RED
    consume();
    repeat (30) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_value", 64'(out_value), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_ready", 64'(seed_ready), 1);
    #2;
    rst_n = 1'b1;
    tick();
    send_seed(32'd96, 32'd993441, 32'd4001, 32'd60211);
    wait_valid(lat);
    chk("arst_latency", 64'(lat), 66);
    chk("arst_seq", 64'(out_value), 444307);

    // Random stream with random backpressure
    for (int it = 0; it < 1000; it++) begin
      s = $urandom;
      a = $urandom;
      c = $urandom;
      m = $urandom;
      if ((it & 3) == 0) m = m & 32'h0000_0fff;
      if (m == 0) m = 32'd1;
      send_seed(s, m, a, c);
      exp_v = lcg_ref(s, a, c, m);
      wait_valid(lat);
      chk("rnd_latency", 64'(lat), 66);
      chk("rnd_value", 64'(out_value), exp_v);
      if ((it & 7) == 0) begin
        n = 0;
        out_ready = 1'($urandom);
        while (!(out_ready && out_valid) && n < 50) begin
          tick();
          out_ready = 1'($urandom);
          n++;
        end
        chk("rnd_hold", 64'(out_value), exp_v);
        tick();
        out_ready = 1'b0;
        exp_v = lcg_ref(32'(exp_v), a, c, m);
        wait_valid(lat);
        chk("rnd_next", 64'(out_value), exp_v);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
